// File: rtl/mem_cyc_seq_pkg.sv
// Shared types and defaults for the memory-cycle sequencer.
package mem_cyc_seq_pkg;

   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAddr = 2'd1,
      StWait = 2'd2
   } state_e;

   typedef enum logic {
      OwnUc = 1'b0,
      OwnPf = 1'b1
   } owner_e;

   localparam logic [7:0] TMO_CYC_DEF = 8'd255;

endpackage

// File: rtl/mem_tmo_cnt.sv
// Saturating WAIT-phase timeout counter with clear, enable and terminal-count flag.
module mem_tmo_cnt
   import mem_cyc_seq_pkg::*;
#(
   parameter int unsigned      TMO_W   = 8,
   parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(TMO_CYC_DEF)
) (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   output logic tc_o
);

   logic [TMO_W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (en_i && (cnt_q < TMO_CYC)) begin
         cnt_d = cnt_q + TMO_W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   // Fires on the increment that reaches TMO_CYC, so WAIT lasts exactly TMO_CYC cycles.
   assign tc_o = en_i && (({1'b0, cnt_q} + (TMO_W + 1)'(1)) >= {1'b0, TMO_CYC});

endmodule

// File: rtl/mem_cyc_seq.sv
// Memory cycle sequencer: arbitrates microcode vs prefetch references onto the CMI bus.
module mem_cyc_seq
   import mem_cyc_seq_pkg::*;
#(
   parameter int unsigned      TMO_W   = 8,
   parameter logic [TMO_W-1:0] TMO_CYC = TMO_W'(TMO_CYC_DEF)
) (
   input  logic b_clk_l,
   input  logic reset_l,
   input  logic ucode_req_h,
   input  logic ucode_read_h,
   input  logic ucode_sec_h,
   input  logic prefetch_req_h,
   input  logic cmi_grant_h,
   input  logic status_valid_l,
   input  logic status_err_h,
   output logic add_reg_ena_h,
   output logic cyc_in_prog_h,
   output logic pf_cyc_h,
   output logic read_h,
   output logic scnd_ref_h,
   output logic ucode_stall_h,
   output logic uc_done_h,
   output logic pf_done_h,
   output logic err_h,
   output logic timeout_h
);

   state_e state_q, state_d;
   owner_e owner_q, owner_d;
   logic   read_q, read_d;
   logic   sec_q, sec_d;
   logic   scnd_q, scnd_d;
   logic   uc_done_q, uc_done_d;
   logic   pf_done_q, pf_done_d;
   logic   err_q, err_d;
   logic   tmo_q, tmo_d;
   logic   cnt_clr, cnt_tc;
   logic   end_pulse;

   assign end_pulse = uc_done_q | pf_done_q | err_q | tmo_q;

   mem_tmo_cnt #(
      .TMO_W   (TMO_W),
      .TMO_CYC (TMO_CYC)
   ) u_tmo_cnt (
      .clk_i  (b_clk_l),
      .rst_ni (reset_l),
      .clr_i  (cnt_clr),
      .en_i   (state_q == StWait),
      .tc_o   (cnt_tc)
   );

   always_ff @(posedge b_clk_l or negedge reset_l) begin
      if (!reset_l) begin
         state_q   <= StIdle;
         owner_q   <= OwnUc;
         read_q    <= 1'b0;
         sec_q     <= 1'b0;
         scnd_q    <= 1'b0;
         uc_done_q <= 1'b0;
         pf_done_q <= 1'b0;
         err_q     <= 1'b0;
         tmo_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         read_q    <= read_d;
         sec_q     <= sec_d;
         scnd_q    <= scnd_d;
         uc_done_q <= uc_done_d;
         pf_done_q <= pf_done_d;
         err_q     <= err_d;
         tmo_q     <= tmo_d;
      end
   end

   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      read_d    = read_q;
      sec_d     = sec_q;
      scnd_d    = scnd_q;
      uc_done_d = 1'b0;
      pf_done_d = 1'b0;
      err_d     = 1'b0;
      tmo_d     = 1'b0;
      cnt_clr   = 1'b0;
      unique case (state_q)
         StIdle: begin
            // The pulse cycle is the mandatory idle gap; requests wait for the next one.
            if (!end_pulse) begin
               if (ucode_req_h) begin
                  state_d = StAddr;
                  owner_d = OwnUc;
                  read_d  = ucode_read_h;
                  sec_d   = ucode_sec_h;
                  scnd_d  = 1'b0;
               end else if (prefetch_req_h) begin
                  state_d = StAddr;
                  owner_d = OwnPf;
                  read_d  = 1'b1;
                  sec_d   = 1'b0;
                  scnd_d  = 1'b0;
               end
            end
         end
         StAddr: begin
            if (cmi_grant_h) begin
               state_d = StWait;
               cnt_clr = 1'b1;
            end else if ((owner_q == OwnPf) && !prefetch_req_h) begin
               state_d = StIdle;
            end
         end
         StWait: begin
            if (!status_valid_l) begin
               if (status_err_h) begin
                  state_d = StIdle;
                  err_d   = 1'b1;
               end else if (sec_q && !scnd_q) begin
                  state_d = StAddr;
                  scnd_d  = 1'b1;
               end else begin
                  state_d   = StIdle;
                  uc_done_d = (owner_q == OwnUc);
                  pf_done_d = (owner_q == OwnPf);
               end
            end else if (cnt_tc) begin
               state_d = StIdle;
               tmo_d   = 1'b1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      add_reg_ena_h = (state_q == StAddr);
      cyc_in_prog_h = (state_q == StWait);
      pf_cyc_h      = (state_q != StIdle) && (owner_q == OwnPf);
      read_h        = (state_q != StIdle) && read_q;
      scnd_ref_h    = (state_q != StIdle) && scnd_q;
      uc_done_h     = uc_done_q;
      pf_done_h     = pf_done_q;
      err_h         = err_q;
      timeout_h     = tmo_q;
      ucode_stall_h = reset_l && ucode_req_h && !(uc_done_q || err_q || tmo_q);
   end

endmodule

// File: tb/tb_mem_cyc_seq.sv
// Self-checking bench for mem_cyc_seq: directed scenarios plus randomized traffic vs a model.
module tb_mem_cyc_seq;

   localparam int TMO = 4;

   logic b_clk_l        = 1'b0;
   logic reset_l        = 1'b0;
   logic ucode_req_h    = 1'b0;
   logic ucode_read_h   = 1'b0;
   logic ucode_sec_h    = 1'b0;
   logic prefetch_req_h = 1'b0;
   logic cmi_grant_h    = 1'b0;
   logic status_valid_l = 1'b1;
   logic status_err_h   = 1'b0;
   logic add_reg_ena_h, cyc_in_prog_h, pf_cyc_h, read_h, scnd_ref_h;
   logic ucode_stall_h, uc_done_h, pf_done_h, err_h, timeout_h;

   mem_cyc_seq #(
      .TMO_W   (8),
      .TMO_CYC (8'd4)
   ) dut (
      .b_clk_l        (b_clk_l),
      .reset_l        (reset_l),
      .ucode_req_h    (ucode_req_h),
      .ucode_read_h   (ucode_read_h),
      .ucode_sec_h    (ucode_sec_h),
      .prefetch_req_h (prefetch_req_h),
      .cmi_grant_h    (cmi_grant_h),
      .status_valid_l (status_valid_l),
      .status_err_h   (status_err_h),
      .add_reg_ena_h  (add_reg_ena_h),
      .cyc_in_prog_h  (cyc_in_prog_h),
      .pf_cyc_h       (pf_cyc_h),
      .read_h         (read_h),
      .scnd_ref_h     (scnd_ref_h),
      .ucode_stall_h  (ucode_stall_h),
      .uc_done_h      (uc_done_h),
      .pf_done_h      (pf_done_h),
      .err_h          (err_h),
      .timeout_h      (timeout_h)
   );

   always #5 b_clk_l = ~b_clk_l;

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string name, input logic act, input logic exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %b expected %b", name, $time, act, exp);
      end
   endtask

   // Model: phase 0 idle, 1 address, 2 waiting; pulse 0 none, 1 uc_done, 2 pf_done, 3 err, 4 tmo.
   int m_phase  = 0;
   int m_waited = 0;
   int m_pulse  = 0;
   bit m_uc     = 1'b1;
   bit m_rd     = 1'b0;
   bit m_sec    = 1'b0;
   bit m_second = 1'b0;

   function automatic void model_reset();
      m_phase  = 0;
      m_waited = 0;
      m_pulse  = 0;
      m_uc     = 1'b1;
      m_rd     = 1'b0;
      m_sec    = 1'b0;
      m_second = 1'b0;
   endfunction

   function automatic void model_step();
      int prev;
      prev    = m_pulse;
      m_pulse = 0;
      case (m_phase)
         0: if (prev == 0) begin
            if (ucode_req_h) begin
               m_phase = 1; m_uc = 1'b1; m_rd = ucode_read_h; m_sec = ucode_sec_h; m_second = 1'b0;
            end else if (prefetch_req_h) begin
               m_phase = 1; m_uc = 1'b0; m_rd = 1'b1; m_sec = 1'b0; m_second = 1'b0;
            end
         end
         1: begin
            if (cmi_grant_h) begin
               m_phase  = 2;
               m_waited = 0;
            end else if (!m_uc && !prefetch_req_h) begin
               m_phase = 0;
            end
         end
         default: begin
            m_waited++;
            if (!status_valid_l) begin
               if (status_err_h) begin
                  m_phase = 0; m_pulse = 3;
               end else if (m_sec && !m_second) begin
                  m_phase = 1; m_second = 1'b1;
               end else begin
                  m_phase = 0; m_pulse = m_uc ? 1 : 2;
               end
            end else if (m_waited >= TMO) begin
               m_phase = 0; m_pulse = 4;
            end
         end
      endcase
   endfunction

   function automatic logic uc_released();
      return (m_pulse == 1) || (m_pulse == 3) || (m_pulse == 4);
   endfunction

   // Model update on each edge, then compare every output slightly after it.
   always @(posedge b_clk_l) begin
      if (!reset_l) model_reset();
      else model_step();
      #2;
      chk("add_reg_ena_h", add_reg_ena_h, m_phase == 1);
      chk("cyc_in_prog_h", cyc_in_prog_h, m_phase == 2);
      chk("pf_cyc_h", pf_cyc_h, (m_phase != 0) && !m_uc);
      chk("read_h", read_h, (m_phase != 0) && m_rd);
      chk("scnd_ref_h", scnd_ref_h, (m_phase != 0) && m_second);
      chk("uc_done_h", uc_done_h, m_pulse == 1);
      chk("pf_done_h", pf_done_h, m_pulse == 2);
      chk("err_h", err_h, m_pulse == 3);
      chk("timeout_h", timeout_h, m_pulse == 4);
      chk("ucode_stall_h", ucode_stall_h, reset_l && ucode_req_h && !uc_released());
   end

   task automatic tick(input int n = 1);
      repeat (n) @(negedge b_clk_l);
   endtask

   task automatic idle_inputs();
      ucode_req_h = 1'b0; prefetch_req_h = 1'b0; cmi_grant_h = 1'b0;
      status_valid_l = 1'b1; status_err_h = 1'b0;
   endtask

   initial begin
      tick(2);
      chk("reset_add", add_reg_ena_h, 1'b0);
      reset_l = 1'b1;

      // UC read, no second reference
      ucode_req_h = 1'b1; ucode_read_h = 1'b1; ucode_sec_h = 1'b0;
      tick();
      chk("uc_addr", add_reg_ena_h, 1'b1);
      chk("uc_stall", ucode_stall_h, 1'b1);
      tick();
      cmi_grant_h = 1'b1;
      tick();
      cmi_grant_h = 1'b0;
      chk("uc_wait", cyc_in_prog_h, 1'b1);
      tick(2);
      status_valid_l = 1'b0;
      tick();
      chk("uc_done_pulse", uc_done_h, 1'b1);
      chk("uc_stall_drop", ucode_stall_h, 1'b0);
      idle_inputs();
      tick();
      chk("uc_done_one", uc_done_h, 1'b0);
      tick();

      // Split UC write
      ucode_req_h = 1'b1; ucode_read_h = 1'b0; ucode_sec_h = 1'b1;
      tick();
      chk("split_first_scnd", scnd_ref_h, 1'b0);
      cmi_grant_h = 1'b1;
      tick();
      cmi_grant_h = 1'b0; status_valid_l = 1'b0;
      tick();
      status_valid_l = 1'b1;
      chk("split_second_addr", add_reg_ena_h, 1'b1);
      chk("split_second_scnd", scnd_ref_h, 1'b1);
      chk("split_no_early_done", uc_done_h, 1'b0);
      chk("split_write", read_h, 1'b0);
      cmi_grant_h = 1'b1;
      tick();
      cmi_grant_h = 1'b0; status_valid_l = 1'b0;
      tick();
      chk("split_done", uc_done_h, 1'b1);
      idle_inputs();
      tick(2);

      // UC and PF together; UC wins, PF follows after one idle cycle
      ucode_req_h = 1'b1; ucode_read_h = 1'b1; ucode_sec_h = 1'b0; prefetch_req_h = 1'b1;
      tick();
      chk("arb_uc_wins", pf_cyc_h, 1'b0);
      cmi_grant_h = 1'b1;
      tick();
      cmi_grant_h = 1'b0; status_valid_l = 1'b0;
      tick();
      status_valid_l = 1'b1; ucode_req_h = 1'b0;
      chk("arb_uc_done", uc_done_h, 1'b1);
      tick();
      chk("arb_gap", add_reg_ena_h, 1'b0);
      tick();
      chk("arb_pf_addr", pf_cyc_h, 1'b1);
      cmi_grant_h = 1'b1;
      tick();
      cmi_grant_h = 1'b0; status_valid_l = 1'b0;
      tick();
      chk("arb_pf_done", pf_done_h, 1'b1);
      idle_inputs();
      tick(2);

      // PF abort before grant, then drop and grant together
      prefetch_req_h = 1'b1;
      tick();
      prefetch_req_h = 1'b0;
      tick();
      chk("pf_abort_idle", add_reg_ena_h, 1'b0);
      chk("pf_abort_nopulse", pf_done_h, 1'b0);
      prefetch_req_h = 1'b1;
      tick();
      prefetch_req_h = 1'b0; cmi_grant_h = 1'b1;
      tick();
      cmi_grant_h = 1'b0;
      chk("pf_grant_wins", cyc_in_prog_h, 1'b1);
      status_valid_l = 1'b0;
      tick();
      idle_inputs();
      tick(2);

      // Timeout after exactly TMO cycles, then status on the deadline cycle
      for (int k = 0; k < 2; k++) begin
         ucode_req_h = 1'b1;
         tick();
         cmi_grant_h = 1'b1;
         tick();
         cmi_grant_h = 1'b0;
         tick(TMO - 1);
         chk("tmo_still_wait", cyc_in_prog_h, 1'b1);
         if (k == 1) status_valid_l = 1'b0;
         tick();
         chk("tmo_pulse", timeout_h, k == 0);
         chk("tmo_status_wins", uc_done_h, k == 1);
         idle_inputs();
         tick(2);
      end

      // Async reset during the second reference's WAIT
      ucode_req_h = 1'b1; ucode_read_h = 1'b0; ucode_sec_h = 1'b1;
      tick();
      cmi_grant_h = 1'b1;
      tick();
      cmi_grant_h = 1'b0; status_valid_l = 1'b0;
      tick();
      status_valid_l = 1'b1; cmi_grant_h = 1'b1;
      tick();
      cmi_grant_h = 1'b0;
      chk("rst_pre_scnd", scnd_ref_h, 1'b1);
      #2 reset_l = 1'b0;
      #1;
      chk("rst_async_wait", cyc_in_prog_h, 1'b0);
      chk("rst_async_scnd", scnd_ref_h, 1'b0);
      chk("rst_async_read", read_h, 1'b0);
      chk("rst_async_stall", ucode_stall_h, 1'b0);
      tick(2);
      reset_l = 1'b1; ucode_sec_h = 1'b0; ucode_read_h = 1'b1;
      tick();
      chk("rst_first_req", add_reg_ena_h, 1'b1);
      cmi_grant_h = 1'b1;
      tick();
      cmi_grant_h = 1'b0; status_valid_l = 1'b0;
      tick();
      chk("rst_recover_done", uc_done_h, 1'b1);
      idle_inputs();
      tick(2);

      // Randomized traffic; microcode holds its request until released
      for (int i = 0; i < 4000; i++) begin
         if (ucode_req_h) begin
            if (uc_released()) ucode_req_h = 1'b0;
         end else begin
            ucode_req_h = ($urandom_range(5) == 0);
         end
         ucode_read_h = $urandom_range(1);
         ucode_sec_h  = $urandom_range(1);
         if ($urandom_range(2) == 0) prefetch_req_h = ~prefetch_req_h;
         cmi_grant_h    = ($urandom_range(2) == 0);
         status_valid_l = ($urandom_range(3) != 0);
         status_err_h   = ($urandom_range(4) == 0);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/mem_cyc_seq.md
MEM_CYC_SEQ -- requirements
Module: mem_cyc_seq

Interface
REQ-001 Parameter TMO_CYC, default 8'd255: B CLK cycles allowed in WAIT before a cycle is declared timed out.
REQ-002 Parameter TMO_W, default 8: width of the timeout counter.
REQ-003 b_clk_l  in  1  sole clock; all state changes on the rising edge of b_clk_l.
REQ-004 reset_l  in  1  reset, asynchronous and active-low.
REQ-005 ucode_req_h  in  1  microcode memory request (bus cycle decoded, not prefetch); held until uc_done_h, err_h or timeout_h.
REQ-006 ucode_read_h  in  1  microcode request is a read; sampled at grant from IDLE.
REQ-007 ucode_sec_h  in  1  microcode request needs a second reference (unaligned); sampled at grant from IDLE.
REQ-008 prefetch_req_h  in  1  I-stream prefetch request; may drop at any time.
REQ-009 cmi_grant_h  in  1  CMI accepted the address of the current reference.
REQ-010 status_valid_l  in  1  CMI cycle status valid, active-low.
REQ-011 status_err_h  in  1  CMI error status; qualified by status_valid_l low.
REQ-012 add_reg_ena_h  out  1  address phase active (state ADDR).
REQ-013 cyc_in_prog_h  out  1  reference issued, awaiting status (state WAIT).
REQ-014 pf_cyc_h  out  1  current owner is prefetch.
REQ-015 read_h  out  1  current cycle is a read; prefetch cycles always read.
REQ-016 scnd_ref_h  out  1  current reference is the second half of a split reference.
REQ-017 ucode_stall_h  out  1  microcode must stall this microcycle.
REQ-018 uc_done_h, pf_done_h  out  1 each  one-cycle completion pulses.
REQ-019 err_h, timeout_h  out  1 each  one-cycle abnormal-termination pulses.

Function
REQ-020 States: IDLE, ADDR, WAIT; encoding is in the shared package.
REQ-021 IDLE: ucode_req_h high -> ADDR, owner UC, latch read_h and ucode_sec_h.
REQ-022 IDLE: else prefetch_req_h high -> ADDR, owner PF, read_h=1, no second reference; microcode always wins a simultaneous request.
REQ-023 ADDR: cmi_grant_h high -> WAIT, timeout counter cleared to 0.
REQ-024 ADDR: owner PF and prefetch_req_h low before grant -> IDLE with no pulse; on the same cycle, grant wins.
REQ-025 WAIT: counter increments each cycle; status_valid_l low with status_err_h high -> IDLE, err_h pulse, pending second reference discarded.
REQ-026 WAIT: good status with second reference pending and scnd_ref_h=0 -> ADDR, scnd_ref_h=1, owner unchanged, no done pulse.
REQ-027 WAIT: good status otherwise -> IDLE, uc_done_h or pf_done_h pulse per owner, scnd_ref_h cleared.
REQ-028 WAIT: counter reaching TMO_CYC with no status -> IDLE, timeout_h pulse; status in the same cycle takes precedence over timeout.
REQ-029 Completion pulses are asserted in the cycle the FSM enters IDLE; a new request is accepted no earlier than the following cycle (minimum one IDLE cycle between references).
REQ-030 ucode_stall_h = ucode_req_h and not uc_done_h, err_h or timeout_h in the same cycle; a prefetch in progress stalls microcode until it completes.
REQ-031 Counter saturates at TMO_CYC; no wrap-around.
REQ-032 pf_cyc_h, read_h and scnd_ref_h are held constant from the ADDR entry until the return to IDLE.

Reset
REQ-033 reset_l low forces IDLE, counter 0, owner UC, and all outputs 0 immediately, including mid-cycle; no pulse is generated for an aborted cycle.
REQ-034 The first request is accepted on the first rising edge after reset_l rises.

Structure
REQ-035 The shared package holds the state enum, the owner enum (UC, PF) and the TMO_CYC default.
REQ-036 One sub-module, mem_tmo_cnt: clear, enable and saturating terminal-count flag, TMO_W wide; all other logic is in mem_cyc_seq.

Verification
REQ-037 UC read, no sec: req -> ADDR; grant 2 cycles later -> WAIT; status 3 cycles later, good -> uc_done_h one pulse; stall drops in that cycle.
REQ-038 Split UC write (sec=1): two ADDR/WAIT pairs, scnd_ref_h=1 on the second only, exactly one uc_done_h, read_h=0 throughout.
REQ-039 UC and PF requests in the same IDLE cycle -> owner UC; PF served after uc_done_h plus one IDLE cycle; pf_done_h pulses.
REQ-040 PF in ADDR, prefetch_req_h drops before grant -> IDLE, no pulses; repeat with drop and grant together -> WAIT.
REQ-041 TMO_CYC=4, no status -> timeout_h exactly 4 cycles after WAIT entry; status_valid_l low on that same cycle -> done pulse, no timeout_h.
REQ-042 reset_l low during WAIT of the second reference -> all outputs 0 asynchronously; after release, a new UC request completes normally.
